// File: rtl/tage_pkg.sv
// Shared types and default geometry for the TAGE table controller.
// The FIFO entry struct here is sized for the default geometry.
package tage_pkg;

  localparam int TAGE_DEF_ENTRIES   = 512;
  localparam int TAGE_DEF_ADDR_W    = $clog2(TAGE_DEF_ENTRIES);
  localparam int TAGE_DEF_DATA_W    = 2;
  localparam int TAGE_DEF_UPD_DEPTH = 4;

  typedef struct packed {
    logic [TAGE_DEF_ADDR_W-1:0] idx;
    logic [TAGE_DEF_DATA_W-1:0] data;
  } tage_wr_req_t;

  typedef enum logic {
    INIT,
    RUN
  } tage_ctrl_state_e;

  // Last winner of a contested write-port arbitration.
  typedef enum logic {
    SRC_UPD,
    SRC_ALC
  } tage_src_e;

endpackage

// File: rtl/tage_table_ctrl_if.sv
// Lookup, update and allocation channels of one TAGE table.
// The controller takes the slave side; the predictor pipeline drives the master side.
interface tage_table_ctrl_if #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 2,
  parameter int CNT_W  = 3
);

  logic              rd_valid;
  logic [ADDR_W-1:0] rd_idx;
  logic              rd_ready;
  logic              rd_data_valid;
  logic [DATA_W-1:0] rd_data;

  logic              upd_valid;
  logic [ADDR_W-1:0] upd_idx;
  logic [DATA_W-1:0] upd_data;
  logic              upd_ready;

  logic              alc_valid;
  logic [ADDR_W-1:0] alc_idx;
  logic [DATA_W-1:0] alc_data;
  logic              alc_ready;

  logic              init_done;
  logic [CNT_W-1:0]  upd_cnt;

  modport master (
    output rd_valid, rd_idx, upd_valid, upd_idx, upd_data,
           alc_valid, alc_idx, alc_data,
    input  rd_ready, rd_data_valid, rd_data, upd_ready, alc_ready,
           init_done, upd_cnt
  );

  modport slave (
    input  rd_valid, rd_idx, upd_valid, upd_idx, upd_data,
           alc_valid, alc_idx, alc_data,
    output rd_ready, rd_data_valid, rd_data, upd_ready, alc_ready,
           init_done, upd_cnt
  );

endinterface

// File: rtl/dual_port_ram.sv
// Simple dual-port RAM: one write port, one registered read port.
// A read of an address written in the same cycle returns the old contents.
module dual_port_ram #(
  parameter int DEPTH  = 512,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int DATA_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] q
);

  logic [DATA_W-1:0] mem [DEPTH];

  // NOTE: the array has no reset so it maps onto block RAM; the controller's
  // init sweep is what gives it defined contents.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // NOTE: non-blocking assignments make a same-cycle read see the pre-write
  // value regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (re) begin
      q <= mem[raddr];
    end
  end

endmodule

// File: rtl/tage_table_ctrl.sv
// TAGE table controller: init sweep, buffered commit updates arbitrated
// against mispredict allocations, and a lookup port with write bypass.
module tage_table_ctrl
  import tage_pkg::*;
#(
  parameter int                NUM_ENTRIES = TAGE_DEF_ENTRIES,
  parameter int                ADDR_W      = $clog2(NUM_ENTRIES),
  parameter int                DATA_W      = TAGE_DEF_DATA_W,
  parameter logic [DATA_W-1:0] INIT_VAL    = '0,
  parameter int                UPD_DEPTH   = TAGE_DEF_UPD_DEPTH
) (
  input logic              clk,
  input logic              rst,
  tage_table_ctrl_if.slave bus
);

  localparam int                PTR_W    = $clog2(UPD_DEPTH);
  localparam int                CNT_W    = PTR_W + 1;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_ENTRIES - 1);

  // Same layout as tage_wr_req_t, sized to this instance's geometry.
  typedef struct packed {
    logic [ADDR_W-1:0] idx;
    logic [DATA_W-1:0] data;
  } wr_req_t;

  tage_ctrl_state_e  state_q, state_d;
  logic [ADDR_W-1:0] sweep_q, sweep_d;
  logic              init_done_q;

  tage_src_e         rr_last_q, rr_last_d;
  wr_req_t           fifo_q [UPD_DEPTH];
  wr_req_t           fifo_head;
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              fifo_full, fifo_pend, alc_pend;
  logic              grant_upd, grant_alc, push, pop, upd_ready;

  logic              ram_we;
  logic [ADDR_W-1:0] ram_waddr;
  logic [DATA_W-1:0] ram_wdata, ram_q;
  logic              rd_acc, byp_hit_d;
  logic              rd_valid_q, byp_hit_q;
  logic [DATA_W-1:0] byp_data_q, hold_q, rd_data;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= INIT;
      sweep_q     <= '0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sweep_q     <= sweep_d;
      init_done_q <= (state_q == RUN);
    end
  end

  // ---------------- FSM: next state ----------------
  // NOTE: every combinational output gets a default first so no path
  // leaves it unassigned and infers a latch.
  always_comb begin
    state_d = state_q;
    sweep_d = sweep_q;
    if (state_q == INIT) begin
      sweep_d = sweep_q + ADDR_W'(1);
      if (sweep_q == LAST_IDX) begin
        state_d = RUN;
      end
    end
  end

  // ---------------- FSM: outputs (write port mux) ----------------
  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = sweep_q;
    ram_wdata = INIT_VAL;
    unique case (state_q)
      INIT: ram_we = 1'b1;
      RUN: begin
        if (grant_upd) begin
          ram_we    = 1'b1;
          ram_waddr = fifo_head.idx;
          ram_wdata = fifo_head.data;
        end else if (grant_alc) begin
          ram_we    = 1'b1;
          ram_waddr = bus.alc_idx;
          ram_wdata = bus.alc_data;
        end
      end
      default: ;
    endcase
  end

  // ---------------- Write-port arbitration ----------------
  // Nothing competes for the port until init_done, which also keeps the
  // single RUN-before-init_done cycle free of writes.
  always_comb begin
    fifo_head = fifo_q[rd_ptr_q];
    fifo_full = (cnt_q == CNT_W'(UPD_DEPTH));
    fifo_pend = init_done_q && (cnt_q != '0);
    alc_pend  = init_done_q && bus.alc_valid;
    grant_upd = fifo_pend && (!alc_pend || fifo_full || rr_last_q == SRC_ALC);
    grant_alc = alc_pend && !grant_upd;
    rr_last_d = rr_last_q;
    if (fifo_pend && alc_pend && !fifo_full) begin
      rr_last_d = grant_upd ? SRC_UPD : SRC_ALC;
    end
    upd_ready = init_done_q && !fifo_full;
    push      = bus.upd_valid && upd_ready;
    pop       = grant_upd;
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // ---------------- Update FIFO ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      rr_last_q <= SRC_UPD;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      cnt_q     <= cnt_d;
      rr_last_q <= rr_last_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_q[wr_ptr_q] <= '{idx: bus.upd_idx, data: bus.upd_data};
    end
  end

  // ---------------- Lookup path with same-cycle write bypass ----------------
  always_comb begin
    rd_acc    = init_done_q && bus.rd_valid;
    byp_hit_d = rd_acc && ram_we && (ram_waddr == bus.rd_idx);
    rd_data   = rd_valid_q ? (byp_hit_q ? byp_data_q : ram_q) : hold_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid_q <= 1'b0;
      byp_hit_q  <= 1'b0;
      byp_data_q <= '0;
      hold_q     <= '0;
    end else begin
      rd_valid_q <= rd_acc;
      if (rd_acc) begin
        byp_hit_q  <= byp_hit_d;
        byp_data_q <= ram_wdata;
      end
      if (rd_valid_q) begin
        hold_q <= rd_data;
      end
    end
  end

  dual_port_ram #(
    .DEPTH  (NUM_ENTRIES),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .re    (rd_acc),
    .raddr (bus.rd_idx),
    .q     (ram_q)
  );

  assign bus.rd_ready      = init_done_q;
  assign bus.rd_data_valid = rd_valid_q;
  assign bus.rd_data       = rd_data;
  assign bus.upd_ready     = upd_ready;
  assign bus.alc_ready     = grant_alc;
  assign bus.init_done     = init_done_q;
  assign bus.upd_cnt       = cnt_q;

endmodule

// File: tb/tb_tage_table_ctrl.sv
// Self-checking bench for tage_table_ctrl: a cycle model predicts handshakes
// and write-port grants; lookup results go through a scoreboard queue.
module tb_tage_table_ctrl;

  localparam int            N     = 16;
  localparam int            AW    = 4;
  localparam int            DW    = 2;
  localparam logic [DW-1:0] IVAL  = 2'b01;
  localparam int            DEPTH = 4;
  localparam int            CW    = 3;

  typedef struct packed {
    logic [AW-1:0] idx;
    logic [DW-1:0] data;
  } req_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  tage_table_ctrl_if #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(CW)) bus ();

  tage_table_ctrl #(
    .NUM_ENTRIES (N),
    .ADDR_W      (AW),
    .DATA_W      (DW),
    .INIT_VAL    (IVAL),
    .UPD_DEPTH   (DEPTH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [DW-1:0] m_mem [N];
  req_t          m_fifo[$];
  logic [DW-1:0] exp_rd_q[$];
  bit            m_rr_alc;      // last contested winner was the allocation
  int            m_run_cycles;  // clock edges since reset release
  bit            m_rdv;
  bit            last_upd_acc, last_alc_acc;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // One clock: check outputs at the negedge, then advance the model at the posedge.
  task automatic step();
    bit            init_e, full, upd_rdy_e, fifo_pend, alc_pend, g_upd, g_alc, rd_acc, we;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd, rd_e;
    req_t          head;
    init_e = 0; full = 0; upd_rdy_e = 0; fifo_pend = 0; alc_pend = 0;
    g_upd = 0; g_alc = 0; rd_acc = 0; we = 0; wa = '0; wd = '0;
    @(negedge clk);
    if (!rst) begin
      init_e    = (m_run_cycles > N);
      full      = (m_fifo.size() == DEPTH);
      upd_rdy_e = init_e && !full;
      fifo_pend = init_e && (m_fifo.size() != 0);
      alc_pend  = init_e && bus.alc_valid;
      if (fifo_pend && alc_pend) g_upd = full || m_rr_alc;
      else                       g_upd = fifo_pend;
      g_alc = alc_pend && !g_upd;
      check("init_done", 32'(bus.init_done), 32'(init_e));
      check("rd_ready",  32'(bus.rd_ready),  32'(init_e));
      check("upd_ready", 32'(bus.upd_ready), 32'(upd_rdy_e));
      check("alc_ready", 32'(bus.alc_ready), 32'(g_alc));
      check("upd_cnt",   32'(bus.upd_cnt),   32'(m_fifo.size()));
      check("rd_data_valid", 32'(bus.rd_data_valid), 32'(m_rdv));
      if (m_rdv && exp_rd_q.size() != 0) begin
        rd_e = exp_rd_q.pop_front();
        check("rd_data", 32'(bus.rd_data), 32'(rd_e));
      end
      if (g_upd) begin
        head = m_fifo[0];
        we = 1; wa = head.idx; wd = head.data;
      end else if (g_alc) begin
        we = 1; wa = bus.alc_idx; wd = bus.alc_data;
      end
      rd_acc = init_e && bus.rd_valid;
      if (rd_acc) exp_rd_q.push_back((we && wa == bus.rd_idx) ? wd : m_mem[bus.rd_idx]);
    end
    @(posedge clk);
    if (rst) begin
      m_fifo.delete();
      exp_rd_q.delete();
      m_rdv = 0; m_rr_alc = 0; m_run_cycles = 0;
      last_upd_acc = 0; last_alc_acc = 0;
      for (int i = 0; i < N; i++) m_mem[i] = IVAL;
    end else begin
      if (we) m_mem[wa] = wd;
      if (g_upd) void'(m_fifo.pop_front());
      if (bus.upd_valid && upd_rdy_e) m_fifo.push_back('{idx: bus.upd_idx, data: bus.upd_data});
      if (fifo_pend && alc_pend && !full) m_rr_alc = g_alc;
      m_rdv        = rd_acc;
      last_upd_acc = bus.upd_valid && upd_rdy_e;
      last_alc_acc = g_alc;
      if (m_run_cycles < 100000) m_run_cycles++;
    end
    #1;
  endtask

  task automatic wait_init(input string tag);
    int cyc = 0;
    while (!bus.init_done && cyc < 100) begin
      step();
      cyc++;
    end
    check(tag, 32'(cyc), 32'(N + 1));
  endtask

  task automatic push_upd(input logic [AW-1:0] idx, input logic [DW-1:0] data);
    int guard = 0;
    bus.upd_valid = 1'b1; bus.upd_idx = idx; bus.upd_data = data;
    do begin
      step();
      guard++;
    end while (!last_upd_acc && guard < 50);
    if (!last_upd_acc) check("upd_timeout", 32'(guard), 32'(0));
    bus.upd_valid = 1'b0;
  endtask

  task automatic read_all();
    for (int i = 0; i < N; i++) begin
      bus.rd_valid = 1'b1; bus.rd_idx = AW'(i);
      step();
    end
    bus.rd_valid = 1'b0;
    step(); step();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    int alc_n, upd_n;
    bus.rd_valid = 0; bus.rd_idx = '0;
    bus.upd_valid = 0; bus.upd_idx = '0; bus.upd_data = '0;
    bus.alc_valid = 0; bus.alc_idx = '0; bus.alc_data = '0;
    for (int i = 0; i < N; i++) m_mem[i] = IVAL;

    // Reset state and init sweep latency, then readback of INIT_VAL.
    rst = 1'b1; idle(2);
    rst = 1'b0;
    check("rst_rd_data", 32'(bus.rd_data), 32'(0));
    check("rst_upd_cnt", 32'(bus.upd_cnt), 32'(0));
    wait_init("init_latency");
    read_all();

    // Reset at sweep ptr 7 with updates/allocations held throughout init.
    rst = 1'b1; idle(1); rst = 1'b0;
    bus.upd_valid = 1; bus.upd_idx = 4'd3; bus.upd_data = 2'b11;
    bus.alc_valid = 1; bus.alc_idx = 4'd9; bus.alc_data = 2'b11;
    idle(7);
    rst = 1'b1; idle(1); rst = 1'b0;
    wait_init("init_latency_restart");
    bus.upd_valid = 0; bus.alc_valid = 0;
    read_all();

    // Five back-to-back updates, no competition.
    for (int i = 0; i < 5; i++) push_upd(AW'(8 + i), DW'(i + 2));
    idle(3);
    read_all();

    // Allocation held against a 2-deep FIFO, then FIFO filled to full.
    alc_n = 0; upd_n = 0;
    for (int c = 0; c < 28; c++) begin
      bus.alc_valid = 1'b1;
      bus.alc_idx   = AW'(alc_n);
      bus.alc_data  = DW'(alc_n + 1);
      bus.upd_valid = (c < 2) || (c >= 10);
      bus.upd_idx   = AW'(15 - (upd_n % 8));
      bus.upd_data  = DW'(upd_n);
      step();
      if (last_alc_acc) alc_n++;
      if (last_upd_acc) upd_n++;
    end
    bus.alc_valid = 0; bus.upd_valid = 0;
    idle(6);
    read_all();

    // Bypass: lookup of idx 5 in the cycle its update is written.
    push_upd(4'd5, 2'b00); idle(2);
    push_upd(4'd5, 2'b11);
    bus.rd_valid = 1; bus.rd_idx = 4'd5;
    step();
    bus.rd_valid = 0;
    idle(2);
    // Different index in the write cycle returns the RAM value.
    push_upd(4'd5, 2'b10);
    bus.rd_valid = 1; bus.rd_idx = 4'd6;
    step();
    bus.rd_valid = 0;
    idle(2);

    // Random mixed traffic; refused requests are held unchanged.
    for (int c = 0; c < 400; c++) begin
      if (!bus.alc_valid || last_alc_acc) begin
        bus.alc_valid = ($urandom_range(0, 2) == 0);
        bus.alc_idx   = AW'($urandom_range(0, N - 1));
        bus.alc_data  = DW'($urandom_range(0, 3));
      end
      if (!bus.upd_valid || last_upd_acc) begin
        bus.upd_valid = ($urandom_range(0, 1) == 0);
        bus.upd_idx   = AW'($urandom_range(0, N - 1));
        bus.upd_data  = DW'($urandom_range(0, 3));
      end
      bus.rd_valid = ($urandom_range(0, 1) == 0);
      bus.rd_idx   = AW'($urandom_range(0, N - 1));
      step();
    end
    bus.alc_valid = 0; bus.upd_valid = 0; bus.rd_valid = 0;
    idle(8);
    read_all();

    check("scoreboard_empty", 32'(exp_rd_q.size()), 32'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
